// File: rtl/rep_burst_gen_if.sv
// Handshake bundle for rep_burst_gen: trigger inputs from the bench side,
// burst output and status counters back from the generator.
interface rep_burst_gen_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             a;
    logic             inject_short;
    logic             b;
    logic             busy;
    logic [CNT_W-1:0] trig_cnt;
    logic [CNT_W-1:0] ext_cnt;

    modport master (
        output en, a, inject_short,
        input  b, busy, trig_cnt, ext_cnt
    );

    modport slave (
        input  en, a, inject_short,
        output b, busy, trig_cnt, ext_cnt
    );
endinterface

// File: rtl/rep_burst_gen.sv
// Stimulus source for "a |-> ##DELAY b[*REP]": each accepted trigger drives b for
// REP cycles (REP-1 when inject_short) starting DELAY cycles later; overlaps merge.
module rep_burst_gen #(
    parameter int REP   = 3,
    parameter int DELAY = 1,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    rep_burst_gen_if.slave bus
);

    localparam int            RW        = $clog2(REP + 1);
    localparam logic [RW-1:0] LEN_FULL  = RW'(REP);
    localparam logic [RW-1:0] LEN_SHORT = RW'(REP - 1);

    logic             accept;
    logic             load;
    logic             load_short;
    logic             pending;
    logic [RW-1:0]    rem;
    logic [RW-1:0]    dec;
    logic [RW-1:0]    len;
    logic [RW-1:0]    rem_next;
    logic             b_int;
    logic [CNT_W-1:0] trig_cnt;
    logic [CNT_W-1:0] ext_cnt;

    assign accept = bus.en & bus.a;

    generate
        if (DELAY == 1) begin : g_direct
            assign load       = accept;
            assign load_short = bus.inject_short;
            assign pending    = 1'b0;
        end else begin : g_line
            logic [DELAY-2:0] dl_valid;
            logic [DELAY-2:0] dl_short;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dl_valid <= '0;
                    dl_short <= '0;
                end else begin
                    dl_valid[0] <= accept;
                    dl_short[0] <= accept & bus.inject_short;
                    for (int i = 1; i < DELAY - 1; i++) begin
                        dl_valid[i] <= dl_valid[i-1];
                        dl_short[i] <= dl_short[i-1];
                    end
                end
            end

            assign load       = dl_valid[DELAY-2];
            assign load_short = dl_short[DELAY-2];
            assign pending    = |dl_valid;
        end
    endgenerate

    // A load only ever extends the remaining burst, so a short trigger inside a
    // longer burst is deliberately masked.
    always_comb begin
        dec      = (rem != '0) ? rem - RW'(1) : '0;
        len      = load_short ? LEN_SHORT : LEN_FULL;
        rem_next = dec;
        if (load && (len > dec)) begin
            rem_next = len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            trig_cnt <= '0;
            ext_cnt  <= '0;
        end else begin
            rem <= rem_next;
            if (accept && (trig_cnt != '1)) begin
                trig_cnt <= trig_cnt + CNT_W'(1);
            end
            if (load && (rem != '0) && (ext_cnt != '1)) begin
                ext_cnt <= ext_cnt + CNT_W'(1);
            end
        end
    end

    assign b_int        = (rem != '0);
    assign bus.b        = b_int;
    assign bus.busy     = b_int | pending;
    assign bus.trig_cnt = trig_cnt;
    assign bus.ext_cnt  = ext_cnt;

endmodule
